// File: rtl/ysyx_23060240_axil_pkg.sv
// Shared types for the AXI-Lite SRAM slave: response codes, FSM states and the
// pmem host interface used as the backing store.
package ysyx_23060240_axil_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_e;

    // Word-addressed sparse store behind pmem_read/pmem_write; unwritten words read 0.
    int          pmem_store [int unsigned];
    int unsigned pmem_rd_cnt;
    int unsigned pmem_wr_cnt;

    function automatic int pmem_read(input int raddr);
        int unsigned key;
        key = unsigned'(raddr) >> 2;
        pmem_rd_cnt = pmem_rd_cnt + 1;
        if (pmem_store.exists(key)) begin
            return pmem_store[key];
        end
        return 0;
    endfunction

    function automatic void pmem_write(input int waddr, input int wdata, input byte wmask);
        int unsigned key;
        int          cur;
        key = unsigned'(waddr) >> 2;
        cur = pmem_store.exists(key) ? pmem_store[key] : 0;
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
                cur[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        pmem_store[key] = cur;
        pmem_wr_cnt = pmem_wr_cnt + 1;
    endfunction

endpackage

// File: rtl/ysyx_23060240_lat_cnt.sv
// Loadable down-counter that stops at zero; done_c flags the zero count.
module ysyx_23060240_lat_cnt
    import ysyx_23060240_axil_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/ysyx_23060240_axil_sram.sv
// AXI-Lite slave in front of pmem with fixed read/write latencies and
// independent, single-outstanding read and write paths.
module ysyx_23060240_axil_sram
    import ysyx_23060240_axil_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WR_LAT   = 1,
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0800_0000
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,

    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,

    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,

    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,

    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned WORDS  = DATA_W / 32;
    localparam int unsigned CMP_W  = ((ADDR_W > 32) ? ADDR_W : 32) + 1;

    r_state_e            r_state;
    w_state_e            w_state;
    logic [ADDR_W-1:0]   ar_addr;
    logic [ADDR_W-1:0]   aw_addr;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;
    logic                aw_got;
    logic                w_got;

    logic rd_load_c, rd_dec_c, rd_done_c;
    logic wr_load_c, wr_dec_c, wr_done_c;
    logic aw_hs_c, w_hs_c;

    // Window compare done one bit wider so MEM_BASE+MEM_SIZE cannot wrap.
    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        logic [CMP_W-1:0] ax, lo, hi;
        ax = CMP_W'(a);
        lo = CMP_W'(MEM_BASE);
        hi = CMP_W'(MEM_BASE) + CMP_W'(MEM_SIZE);
        return (ax >= lo) && (ax < hi);
    endfunction

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(STRB_W - 1);
    endfunction

    // Wide beats are split into 32-bit pmem accesses, lower word first.
    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < int'(WORDS); k++) begin
            d[k*32 +: 32] = 32'(pmem_read(int'(32'(a) + 32'(k * 4))));
        end
        return d;
    endfunction

    function automatic void mem_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                   input logic [STRB_W-1:0] m);
        for (int k = 0; k < int'(WORDS); k++) begin
            pmem_write(int'(32'(a) + 32'(k * 4)), int'(d[k*32 +: 32]),
                       byte'({4'b0000, m[k*4 +: 4]}));
        end
    endfunction

    assign aw_hs_c   = awvalid && awready;
    assign w_hs_c    = wvalid && wready;
    assign rd_load_c = (r_state == R_IDLE) && arvalid && arready;
    assign rd_dec_c  = (r_state == R_WAIT);
    assign wr_load_c = (w_state == W_IDLE) && (aw_got || aw_hs_c) && (w_got || w_hs_c);
    assign wr_dec_c  = (w_state == W_WAIT);

    ysyx_23060240_lat_cnt u_rd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_load_c),
        .load_val (CNT_W'(RD_LAT - 1)),
        .dec      (rd_dec_c),
        .done_c   (rd_done_c)
    );

    ysyx_23060240_lat_cnt u_wr_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_load_c),
        .load_val (CNT_W'(WR_LAT - 1)),
        .dec      (wr_dec_c),
        .done_c   (wr_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            ar_addr <= '0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            arready <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            bvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
            bresp   <= OKAY;
        end else begin
            // Read path sits ahead of the write path so a same-cycle commit is not seen.
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        ar_addr <= araddr;
                        arready <= 1'b0;
                        r_state <= R_WAIT;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rd_done_c) begin
                        if (in_window(ar_addr)) begin
                            rdata <= mem_rd(align(ar_addr));
                            rresp <= OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= DECERR;
                        end
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase

            case (w_state)
                W_IDLE: begin
                    if (aw_hs_c) begin
                        aw_addr <= awaddr;
                        aw_got  <= 1'b1;
                        awready <= 1'b0;
                    end else if (!aw_got) begin
                        awready <= 1'b1;
                    end
                    if (w_hs_c) begin
                        w_data <= wdata;
                        w_strb <= wstrb;
                        w_got  <= 1'b1;
                        wready <= 1'b0;
                    end else if (!w_got) begin
                        wready <= 1'b1;
                    end
                    if (wr_load_c) begin
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (wr_done_c) begin
                        if (in_window(aw_addr)) begin
                            if (w_strb != '0) begin
                                mem_wr(align(aw_addr), w_data, w_strb);
                            end
                            bresp <= OKAY;
                        end else begin
                            bresp <= DECERR;
                        end
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_axil_sram.sv
// Bench for the AXI-Lite SRAM: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ysyx_23060240_axil_sram;

    localparam int unsigned RD_LAT = 3;
    localparam int unsigned WR_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    always #5 clk = ~clk;

    ysyx_23060240_axil_sram #(
        .ADDR_W (32), .DATA_W (32), .RD_LAT (RD_LAT), .WR_LAT (WR_LAT),
        .MEM_BASE (32'h8000_0000), .MEM_SIZE (32'h0800_0000)
    ) dut (
        .clk (clk), .rst (rst),
        .araddr (araddr), .arvalid (arvalid), .arready (arready),
        .rdata (rdata), .rresp (rresp), .rvalid (rvalid), .rready (rready),
        .awaddr (awaddr), .awvalid (awvalid), .awready (awready),
        .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready),
        .bresp (bresp), .bvalid (bvalid), .bready (bready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference memory and address map
    logic [31:0] mdl_mem [logic [31:0]];

    function automatic bit in_win(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8800_0000);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & 32'hFFFF_FFFC;
        return mdl_mem.exists(k) ? mdl_mem[k] : 32'h0;
    endfunction

    function automatic void mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] k, cur;
        k = a & 32'hFFFF_FFFC;
        cur = mdl_mem.exists(k) ? mdl_mem[k] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        mdl_mem[k] = cur;
    endfunction

    // Transaction-level state: what the slave owes the master in the current cycle
    bit          m_rst = 1'b1;
    bit          rd_busy = 1'b0, rd_valid = 1'b0;
    int          rd_wait = 0;
    logic [31:0] rd_addr = '0, rd_data = '0;
    logic [1:0]  rd_resp = '0;
    bit          aw_got = 1'b0, w_got = 1'b0, b_valid = 1'b0;
    int          w_phase = 0;
    int          wr_wait = 0;
    logic [31:0] aw_addr_m = '0, wd_m = '0;
    logic [3:0]  ws_m = '0;
    logic [1:0]  b_resp = '0;
    bit          ar_rdy, aw_rdy, w_rdy;

    initial begin
        forever begin
            @(negedge clk);
            ar_rdy = !m_rst && !rd_busy;
            aw_rdy = !m_rst && (w_phase == 0) && !aw_got;
            w_rdy  = !m_rst && (w_phase == 0) && !w_got;
            chk("arready", 64'(arready), 64'(ar_rdy));
            chk("awready", 64'(awready), 64'(aw_rdy));
            chk("wready",  64'(wready),  64'(w_rdy));
            chk("rvalid",  64'(rvalid),  64'(rd_valid));
            chk("bvalid",  64'(bvalid),  64'(b_valid));
            if (rd_valid || m_rst) begin
                chk("rdata", 64'(rdata), 64'(rd_data));
                chk("rresp", 64'(rresp), 64'(rd_resp));
            end
            if (b_valid || m_rst) chk("bresp", 64'(bresp), 64'(b_resp));

            // Advance to what the coming clock edge produces
            if (rst) begin
                m_rst = 1'b1; rd_busy = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_resp = '0;
                aw_got = 1'b0; w_got = 1'b0; w_phase = 0; b_valid = 1'b0; b_resp = '0;
            end else begin
                m_rst = 1'b0;
                if (rd_valid) begin
                    if (rready) begin rd_valid = 1'b0; rd_busy = 1'b0; end
                end else if (rd_busy) begin
                    if (rd_wait == 1) begin
                        rd_data  = in_win(rd_addr) ? mdl_rd(rd_addr) : 32'h0;
                        rd_resp  = in_win(rd_addr) ? 2'b00 : 2'b11;
                        rd_valid = 1'b1;
                    end else rd_wait--;
                end else if (arvalid && ar_rdy) begin
                    rd_busy = 1'b1; rd_wait = RD_LAT; rd_addr = araddr;
                end

                if (w_phase == 0) begin
                    if (awvalid && aw_rdy) begin aw_got = 1'b1; aw_addr_m = awaddr; end
                    if (wvalid && w_rdy) begin w_got = 1'b1; wd_m = wdata; ws_m = wstrb; end
                    if (aw_got && w_got) begin w_phase = 1; wr_wait = WR_LAT; end
                end else if (w_phase == 1) begin
                    if (wr_wait == 1) begin
                        if (in_win(aw_addr_m)) mdl_wr(aw_addr_m, wd_m, ws_m);
                        b_resp = in_win(aw_addr_m) ? 2'b00 : 2'b11;
                        b_valid = 1'b1; w_phase = 2;
                    end else wr_wait--;
                end else if (bready) begin
                    b_valid = 1'b0; w_phase = 0; aw_got = 1'b0; w_got = 1'b0;
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n;
        @(posedge clk); #1; araddr = a; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin n++; @(negedge clk); end
        if (!arready) chk("ar_timeout", 0, 1);
        @(posedge clk); #1; arvalid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rvalid && lat < 50) begin lat++; @(negedge clk); end
        if (!rvalid) chk("r_timeout", 0, 1);
        d = rdata; resp = rresp;
        repeat (hold) @(negedge clk);
        @(posedge clk); #1; rready = 1'b1;
        @(posedge clk); #1; rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output int lat);
        int aw_cyc;
        int n;
        aw_cyc = 0;
        fork
            begin
                int k;
                repeat (aw_dly) @(posedge clk);
                @(posedge clk); #1; awaddr = a; awvalid = 1'b1;
                k = 0;
                @(negedge clk);
                while (!awready && k < 50) begin k++; @(negedge clk); end
                if (!awready) chk("aw_timeout", 0, 1);
                @(posedge clk); #1; awvalid = 1'b0; aw_cyc = cyc;
            end
            begin
                int k;
                repeat (w_dly) @(posedge clk);
                @(posedge clk); #1; wdata = d; wstrb = s; wvalid = 1'b1;
                k = 0;
                @(negedge clk);
                while (!wready && k < 50) begin k++; @(negedge clk); end
                if (!wready) chk("w_timeout", 0, 1);
                @(posedge clk); #1; wvalid = 1'b0;
            end
        join
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin n++; @(negedge clk); end
        if (!bvalid) chk("b_timeout", 0, 1);
        lat = cyc - aw_cyc;
        resp = bresp;
        @(posedge clk); #1; bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [31:0] d, d_old;
    logic [1:0]  r, wr;
    int          lat, wlat;
    int unsigned c_rd, c_wr;

    initial begin
        // Reset held for three edges
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_arready", 64'(arready), 0);
        chk("rst_awready", 64'(awready), 0);
        @(negedge clk);
        chk("post_rst_arready", 64'(arready), 1);
        chk("post_rst_awready", 64'(awready), 1);
        chk("post_rst_wready",  64'(wready),  1);

        // Preload through the bus
        c_wr = ysyx_23060240_axil_pkg::pmem_wr_cnt;
        do_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, wr, wlat);
        chk("preload_bresp", 64'(wr), 0);
        chk("preload_wr_calls", 64'(ysyx_23060240_axil_pkg::pmem_wr_cnt - c_wr), 1);
        do_write(32'h8000_0010, 32'hAABB_CCDD, 4'hF, 0, 0, wr, wlat);

        // Read with latency 3, response held 4 cycles
        do_read(32'h8000_0004, 4, d, r, lat);
        chk("rd_data", 64'(d), 64'h0000_0000_DEAD_BEEF);
        chk("rd_resp", 64'(r), 0);
        chk("rd_lat",  64'(lat), 3);

        // W one cycle ahead of AW, partial strobe
        c_wr = ysyx_23060240_axil_pkg::pmem_wr_cnt;
        do_write(32'h8000_0010, 32'h1234_5678, 4'b0011, 1, 0, wr, wlat);
        chk("part_wr_calls", 64'(ysyx_23060240_axil_pkg::pmem_wr_cnt - c_wr), 1);
        chk("part_bresp", 64'(wr), 0);
        chk("part_wlat",  64'(wlat), 2);
        do_read(32'h8000_0010, 0, d, r, lat);
        chk("part_rd", 64'(d), 64'h0000_0000_AABB_5678);

        // Out-of-window accesses
        c_rd = ysyx_23060240_axil_pkg::pmem_rd_cnt;
        c_wr = ysyx_23060240_axil_pkg::pmem_wr_cnt;
        do_read(32'h0000_1000, 0, d, r, lat);
        chk("dec_rdata", 64'(d), 0);
        chk("dec_rresp", 64'(r), 3);
        do_write(32'h9000_0000, 32'h5555_5555, 4'hF, 0, 0, wr, wlat);
        chk("dec_bresp", 64'(wr), 3);
        chk("dec_rd_calls", 64'(ysyx_23060240_axil_pkg::pmem_rd_cnt - c_rd), 0);
        chk("dec_wr_calls", 64'(ysyx_23060240_axil_pkg::pmem_wr_cnt - c_wr), 0);

        // Zero strobe leaves memory alone
        c_wr = ysyx_23060240_axil_pkg::pmem_wr_cnt;
        do_write(32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 0, 0, wr, wlat);
        chk("zstrb_bresp", 64'(wr), 0);
        chk("zstrb_wr_calls", 64'(ysyx_23060240_axil_pkg::pmem_wr_cnt - c_wr), 0);
        do_read(32'h8000_0004, 0, d, r, lat);
        chk("zstrb_rd", 64'(d), 64'h0000_0000_DEAD_BEEF);

        // AW two cycles ahead of W, unaligned address
        do_write(32'h8000_000A, 32'h0BAD_F00D, 4'hF, 0, 2, wr, wlat);
        do_read(32'h8000_0008, 1, d, r, lat);
        chk("awfirst_rd", 64'(d), 64'h0000_0000_0BAD_F00D);

        // Read sample and write commit land on the same edge
        fork
            do_read(32'h8000_0010, 0, d_old, r, lat);
            do_write(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 1, 1, wr, wlat);
        join
        chk("same_cyc_old", 64'(d_old), 64'h0000_0000_AABB_5678);
        do_read(32'h8000_0010, 0, d, r, lat);
        chk("same_cyc_new", 64'(d), 64'h0000_0000_CAFE_F00D);

        // Reset while the write is waiting on its latency
        c_wr = ysyx_23060240_axil_pkg::pmem_wr_cnt;
        @(posedge clk); #1;
        awaddr = 32'h8000_0020; awvalid = 1'b1;
        wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstw_bvalid", 64'(bvalid), 0);
        chk("rstw_wr_calls", 64'(ysyx_23060240_axil_pkg::pmem_wr_cnt - c_wr), 0);
        do_write(32'h8000_0024, 32'h0102_0304, 4'hF, 0, 0, wr, wlat);
        chk("rstw_new_bresp", 64'(wr), 0);
        do_read(32'h8000_0020, 0, d, r, lat);
        chk("rstw_dropped", 64'(d), 0);
        do_read(32'h8000_0024, 0, d, r, lat);
        chk("rstw_new_rd", 64'(d), 64'h0000_0000_0102_0304);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_23060240_axil_sram.md
YSYX_23060240_AXIL_SRAM -- requirements
Module: ysyx_23060240_axil_sram

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width (32 or 64); STRB_W = DATA_W/8.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning cycles from AR handshake to RVALID (1..15).
REQ-004 The block SHALL have parameter WR_LAT, default 1, meaning cycles from AW+W both captured to BVALID (1..15).
REQ-005 The block SHALL have parameters MEM_BASE, default 32'h8000_0000, and MEM_SIZE, default 32'h0800_0000, together meaning the decoded window.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have AR channel ports: araddr in ADDR_W, arvalid in 1, arready out 1.
REQ-009 The block SHALL have R channel ports: rdata out DATA_W, rresp out 2, rvalid out 1, rready in 1.
REQ-010 The block SHALL have AW channel ports: awaddr in ADDR_W, awvalid in 1, awready out 1.
REQ-011 The block SHALL have W channel ports: wdata in DATA_W, wstrb in STRB_W, wvalid in 1, wready out 1.
REQ-012 The block SHALL have B channel ports: bresp out 2, bvalid out 1, bready in 1.

Function
REQ-013 Read FSM SHALL have states R_IDLE, R_WAIT and R_RESP; arready SHALL be 1 only in R_IDLE.
REQ-014 On arvalid&&arready the block SHALL latch araddr and enter R_WAIT with its counter set to RD_LAT-1; in R_WAIT at count 0 it SHALL sample memory into rdata and enter R_RESP, so RVALID rises exactly RD_LAT cycles after the AR handshake.
REQ-015 In R_RESP, rvalid SHALL be 1 and rdata/rresp SHALL be held stable until rready; on rvalid&&rready the block SHALL return to R_IDLE, with no back-to-back AR accept in the same cycle.
REQ-016 Memory access SHALL go through DPI pmem_read/pmem_write on the DATA_W-aligned address (low log2(STRB_W) bits forced to 0); for DATA_W=64, two 32-bit accesses (lower word first) SHALL be made.
REQ-017 Write FSM SHALL have states W_IDLE, W_WAIT and W_RESP; awready and wready SHALL each be 1 in W_IDLE until their own channel is captured, and AW and W SHALL be accepted in either order or in the same cycle.
REQ-018 Once both AW and W are captured, the block SHALL enter W_WAIT with its counter set to WR_LAT-1; at count 0 it SHALL issue exactly one pmem_write with wstrb as the mask and enter W_RESP.
REQ-019 In W_RESP, bvalid SHALL be held until bready; on bvalid&&bready the block SHALL return to W_IDLE.
REQ-020 For an address outside [MEM_BASE, MEM_BASE+MEM_SIZE), no DPI call SHALL be made, rdata SHALL be 0 and rresp/bresp SHALL be DECERR (2'b11); otherwise the response SHALL be OKAY (2'b00).
REQ-021 A wstrb of all zeros SHALL produce no pmem_write and bresp OKAY.
REQ-022 The read and write paths SHALL be fully independent; if the read sample and the write commit fall in the same cycle to the same address, the read SHALL return the pre-write data.
REQ-023 At most one read and one write SHALL be outstanding; there SHALL be no ID/burst support.

Reset
REQ-024 When rst=1 at a clk edge, the block SHALL enter R_IDLE and W_IDLE, clear both counters and clear captured flags.
REQ-025 Reset values SHALL be: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; arready/awready/wready SHALL go to 1 in the first cycle after rst deasserts.
REQ-026 When reset is asserted mid-transaction, the pending transaction SHALL be dropped with no pmem_write issued and no response delivered.

Structure
REQ-027 Package ysyx_23060240_axil_pkg SHALL hold the resp codes (OKAY, DECERR) and the read/write FSM state enums.
REQ-028 One sub-module, ysyx_23060240_lat_cnt (a loadable 4-bit down-counter with a done flag), SHALL be instantiated once per path.
REQ-029 The pmem_write DPI call SHALL be made only inside the clocked process, never in combinational logic.

Verification
REQ-030 Reset: hold rst for 3 cycles, then release -> all outputs 0 during reset; arready=awready=wready=1 in the cycle after release.
REQ-031 Read, RD_LAT=3, araddr=0x8000_0004 with memory holding 0xDEADBEEF -> rvalid rises 3 cycles after the handshake, rdata=0xDEADBEEF, rresp=0; holding rready=0 for 4 cycles keeps rdata stable.
REQ-032 Write with W one cycle before AW, addr=0x8000_0010, data=0x12345678, wstrb=4'b0011, WR_LAT=2 -> exactly one pmem_write with mask 0x3; bvalid rises 2 cycles after AW capture; a subsequent read returns 0x????5678 with the low half updated.
REQ-033 Read at 0x0000_1000 and write at 0x9000_0000 -> rresp=DECERR with rdata=0, bresp=DECERR, and no DPI calls.
REQ-034 Concurrent read and write to the same address committing in the same cycle -> the read returns old data and a later read returns new data.
REQ-035 Assert rst during W_WAIT -> no pmem_write occurs, bvalid stays 0, and the block accepts a new AW after reset.
